// File: rtl/game_timer_multi.sv
// Multi-channel game seconds timer: NUM_CH independent up/down counters on clk_game.
// Optional macro GAME_TIMER_BCD_EN adds the registered bcd_flat output.
module game_timer_multi #(
  parameter int NUM_CH        = 2,
  parameter int TICKS_PER_SEC = 60,
  parameter int SEC_W         = 8,
  parameter int MAX_SEC       = 99
) (
  input  logic                    clk_game,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH-1:0]       ch_clear,
  input  logic [NUM_CH-1:0]       ch_load,
  input  logic [NUM_CH-1:0]       ch_down,
  input  logic [NUM_CH*SEC_W-1:0] load_value,
  output logic [NUM_CH*SEC_W-1:0] seconds_flat,
  output logic [NUM_CH-1:0]       sec_pulse,
  output logic [NUM_CH-1:0]       expire_pulse,
  output logic [NUM_CH-1:0]       expired
`ifdef GAME_TIMER_BCD_EN
  ,
  output logic [NUM_CH*8-1:0]     bcd_flat
`endif
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [SEC_W-1:0]  MAX_V     = SEC_W'(MAX_SEC);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("game_timer_multi: NUM_CH must be 1..8");
  end
  if (MAX_SEC >= 2**SEC_W) begin : g_bad_max_sec
    $error("game_timer_multi: MAX_SEC must fit in SEC_W bits");
  end

`ifdef GAME_TIMER_BCD_EN
  if (MAX_SEC > 99) begin : g_bad_bcd_range
    $error("game_timer_multi: BCD output needs MAX_SEC <= 99");
  end

  function automatic logic [7:0] to_bcd(input logic [SEC_W-1:0] v);
    int t;
    t = 32'(v);
    return {4'(t / 10), 4'(t % 10)};
  endfunction
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [SEC_W-1:0]  sec_q, sec_d, sec_step, lv;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic              sec_pulse_q, sec_pulse_d;
    logic              exp_pulse_q, exp_pulse_d;
    logic              expired_q, expired_d;

    assign lv = load_value[i*SEC_W +: SEC_W];

    // Priority clear > load > count; DONE holds until clear or load.
    always_comb begin
      state_d     = state_q;
      sec_d       = sec_q;
      sec_step    = sec_q;
      tick_d      = tick_q;
      sec_pulse_d = 1'b0;
      exp_pulse_d = 1'b0;
      expired_d   = expired_q;
      if (ch_clear[i]) begin
        state_d   = IDLE;
        sec_d     = '0;
        tick_d    = '0;
        expired_d = 1'b0;
      end else if (ch_load[i]) begin
        state_d   = IDLE;
        sec_d     = (lv > MAX_V) ? MAX_V : lv;
        tick_d    = '0;
        expired_d = 1'b0;
      end else if (state_q != DONE) begin
        if (!ch_enable[i]) begin
          state_d = IDLE;
        end else if (state_q == IDLE &&
                     (ch_down[i] ? (sec_q == '0) : (sec_q == MAX_V))) begin
          state_d     = DONE;
          expired_d   = 1'b1;
          exp_pulse_d = 1'b1;
        end else begin
          state_d = RUN;
          if (tick_q == TICK_LAST) begin
            tick_d = '0;
            if (ch_down[i])
              sec_step = (sec_q != '0) ? sec_q - SEC_W'(1) : sec_q;
            else
              sec_step = (sec_q < MAX_V) ? sec_q + SEC_W'(1) : MAX_V;
            sec_d       = sec_step;
            sec_pulse_d = (sec_step != sec_q);
            if (ch_down[i] ? (sec_step == '0) : (sec_step == MAX_V)) begin
              state_d     = DONE;
              expired_d   = 1'b1;
              exp_pulse_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + TICK_W'(1);
          end
        end
      end
    end

    always_ff @(posedge clk_game) begin
      if (!reset) begin
        state_q     <= IDLE;
        sec_q       <= '0;
        tick_q      <= '0;
        sec_pulse_q <= 1'b0;
        exp_pulse_q <= 1'b0;
        expired_q   <= 1'b0;
      end else begin
        state_q     <= state_d;
        sec_q       <= sec_d;
        tick_q      <= tick_d;
        sec_pulse_q <= sec_pulse_d;
        exp_pulse_q <= exp_pulse_d;
        expired_q   <= expired_d;
      end
    end

    assign seconds_flat[i*SEC_W +: SEC_W] = sec_q;
    assign sec_pulse[i]    = sec_pulse_q;
    assign expire_pulse[i] = exp_pulse_q;
    assign expired[i]      = expired_q;

`ifdef GAME_TIMER_BCD_EN
    logic [7:0] bcd_q;

    // Converted from the next seconds value so BCD lands with seconds_flat.
    always_ff @(posedge clk_game) begin
      if (!reset)
        bcd_q <= '0;
      else
        bcd_q <= to_bcd(sec_d);
    end

    assign bcd_flat[i*8 +: 8] = bcd_q;
`endif
  end

endmodule

// File: tb/tb_game_timer_multi.sv
// Directed self-checking bench for game_timer_multi (two channels, 60 ticks/s, MAX 99).
// Build with GAME_TIMER_BCD_EN defined to also check bcd_flat.
module tb_game_timer_multi;

  logic        clk_game = 1'b0;
  logic        reset;
  logic [1:0]  ch_enable, ch_clear, ch_load, ch_down;
  logic [15:0] load_value;
  logic [15:0] seconds_flat;
  logic [1:0]  sec_pulse, expire_pulse, expired;
`ifdef GAME_TIMER_BCD_EN
  logic [15:0] bcd_flat;
`endif

  int compare_count = 0;
  int error_count   = 0;
  int pulse_seen;

  game_timer_multi #(
    .NUM_CH(2), .TICKS_PER_SEC(60), .SEC_W(8), .MAX_SEC(99)
  ) dut (
    .clk_game(clk_game),
    .reset(reset),
    .ch_enable(ch_enable),
    .ch_clear(ch_clear),
    .ch_load(ch_load),
    .ch_down(ch_down),
    .load_value(load_value),
    .seconds_flat(seconds_flat),
    .sec_pulse(sec_pulse),
    .expire_pulse(expire_pulse),
    .expired(expired)
`ifdef GAME_TIMER_BCD_EN
    ,
    .bcd_flat(bcd_flat)
`endif
  );

  always #5 clk_game = ~clk_game;

  // Advance n clock edges, landing 1 time unit after the last edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk_game);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    if (obs !== exp) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] sec_of(input int ch);
    return seconds_flat[ch*8 +: 8];
  endfunction

  initial begin
    reset = 1'b0; ch_enable = '0; ch_clear = '0; ch_load = '0; ch_down = '0;
    load_value = '0;
    applyStimulus(3);
    checkOutput("reset_sec0", sec_of(0), 0);
    checkOutput("reset_sec1", sec_of(1), 0);
    checkOutput("reset_expired", expired, 0);
    checkOutput("reset_pulses", {sec_pulse, expire_pulse}, 0);
    reset = 1'b1;

    // ch0 up-count to saturation
    ch_enable[0] = 1'b1;
    applyStimulus(59);
    checkOutput("up_sec_59", sec_of(0), 0);
    applyStimulus(1);
    checkOutput("up_sec_60", sec_of(0), 1);
    checkOutput("up_pulse_60", sec_pulse[0], 1);
    applyStimulus(1);
    checkOutput("up_pulse_61", sec_pulse[0], 0);
    applyStimulus(59);
    checkOutput("up_sec_120", sec_of(0), 2);
    checkOutput("up_pulse_120", sec_pulse[0], 1);
    applyStimulus(5819);
    checkOutput("up_sec_5939", sec_of(0), 98);
    checkOutput("up_expired_5939", expired[0], 0);
    applyStimulus(1);
    checkOutput("up_sec_5940", sec_of(0), 99);
    checkOutput("up_expired_5940", expired[0], 1);
    checkOutput("up_exp_pulse_5940", expire_pulse[0], 1);
    checkOutput("up_sec_pulse_5940", sec_pulse[0], 1);
    applyStimulus(1);
    checkOutput("up_exp_pulse_once", expire_pulse[0], 0);
    pulse_seen = 0;
    for (int k = 0; k < 200; k++) begin
      applyStimulus(1);
      pulse_seen += int'(sec_pulse[0]) + int'(expire_pulse[0]);
    end
    checkOutput("sat_no_pulses", pulse_seen, 0);
    checkOutput("sat_sec_hold", sec_of(0), 99);
    checkOutput("sat_ch1_untouched", sec_of(1), 0);

    // ch1 down-count from a load of 3
    ch_load[1] = 1'b1; load_value[15:8] = 8'd3;
    applyStimulus(1);
    checkOutput("dn_load3", sec_of(1), 3);
    ch_load[1] = 1'b0; ch_down[1] = 1'b1; ch_enable[1] = 1'b1;
    applyStimulus(60);
    checkOutput("dn_sec_60", sec_of(1), 2);
    checkOutput("dn_pulse_60", sec_pulse[1], 1);
    applyStimulus(60);
    checkOutput("dn_sec_120", sec_of(1), 1);
    checkOutput("dn_expired_120", expired[1], 0);
    applyStimulus(60);
    checkOutput("dn_sec_180", sec_of(1), 0);
    checkOutput("dn_exp_pulse_180", expire_pulse[1], 1);
    checkOutput("dn_expired_180", expired[1], 1);
    ch_load[1] = 1'b1; ch_enable[1] = 1'b0; load_value[15:8] = 8'd200;
    applyStimulus(1);
    checkOutput("load_clamp", sec_of(1), 99);
    checkOutput("load_clr_expired", expired[1], 0);
    ch_load[1] = 1'b0;
    checkOutput("ch0_still_done", {sec_of(0), 7'd0, expired[0]}, {8'd99, 8'd1});

    // clear and load together on ch0: clear wins
    ch_clear[0] = 1'b1; ch_load[0] = 1'b1; ch_enable[0] = 1'b0; load_value[7:0] = 8'd50;
    applyStimulus(1);
    checkOutput("clr_over_load", sec_of(0), 0);
    checkOutput("clr_expired", expired[0], 0);
    ch_clear[0] = 1'b0; ch_load[0] = 1'b0;

    // pause keeps the partial tick count
    ch_enable[0] = 1'b1;
    applyStimulus(30);
    ch_enable[0] = 1'b0;
    applyStimulus(100);
    checkOutput("pause_sec", sec_of(0), 0);
    ch_enable[0] = 1'b1;
    applyStimulus(29);
    checkOutput("resume_29", sec_of(0), 0);
    applyStimulus(1);
    checkOutput("resume_30", sec_of(0), 1);
    checkOutput("resume_pulse", sec_pulse[0], 1);

    // load on a boundary cycle beats the step
    applyStimulus(59);
    checkOutput("pre_boundary", sec_of(0), 1);
    ch_load[0] = 1'b1; load_value[7:0] = 8'd20;
    applyStimulus(1);
    checkOutput("load_on_boundary", sec_of(0), 20);
    checkOutput("load_no_pulse", sec_pulse[0], 0);
    ch_load[0] = 1'b0;
    checkOutput("ch1_unaffected", {sec_of(1), 7'd0, expired[1]}, {8'd99, 8'd0});

    // reset in mid-count, then restart from tick 0
    applyStimulus(10);
    reset = 1'b0;
    applyStimulus(3);
    checkOutput("midreset_sec", seconds_flat, 0);
    checkOutput("midreset_flags", {sec_pulse, expire_pulse, expired}, 0);
    reset = 1'b1;
    applyStimulus(59);
    checkOutput("restart_59", sec_of(0), 0);
    applyStimulus(1);
    checkOutput("restart_60", sec_of(0), 1);

    // degenerate start: down mode at zero
    ch_down[1] = 1'b1; ch_enable[1] = 1'b1;
    applyStimulus(1);
    checkOutput("degen_exp_pulse", expire_pulse[1], 1);
    checkOutput("degen_expired", expired[1], 1);
    checkOutput("degen_no_sec_pulse", sec_pulse[1], 0);
    applyStimulus(1);
    checkOutput("degen_pulse_once", expire_pulse[1], 0);
    checkOutput("degen_sec", sec_of(1), 0);

    ch_load[0] = 1'b1; load_value[7:0] = 8'd47;
    applyStimulus(1);
    ch_load[0] = 1'b0;
    checkOutput("load47", sec_of(0), 47);
`ifdef GAME_TIMER_BCD_EN
    checkOutput("bcd47", bcd_flat[7:0], 8'h47);
    checkOutput("bcd_ch1_zero", bcd_flat[15:8], 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, error_count);
    $finish;
  end

endmodule

// File: doc/game_timer_multi.md
Name: game_timer_multi

Overview:
- Parametrised successor to the single-channel seconds timer.
- NUM_CH independent second counters, all driven from the game-tick clock.
- Each channel counts up or down, is loadable, saturates at MAX_SEC or 0, and flags expiry.
- Feeds the HUD (round timer, power-up countdowns) and the game-state FSM (time-out detection).

Parameters:
- NUM_CH, 2: number of independent timer channels (1..8).
- TICKS_PER_SEC, 60: clk_game cycles per second.
- SEC_W, 8: width of each seconds counter.
- MAX_SEC, 99: up-count ceiling and load clamp; must be < 2**SEC_W.

Ports:
- clk_game  in  1  game-tick clock (60 Hz).
- reset  in  1  synchronous, active-low reset.
- ch_enable  in  NUM_CH  per-channel count enable; low = pause.
- ch_clear  in  NUM_CH  per-channel synchronous clear.
- ch_load  in  NUM_CH  per-channel load strobe.
- ch_down  in  NUM_CH  per-channel mode: 1 = count down, 0 = count up.
- load_value  in  NUM_CH*SEC_W  per-channel load values; channel i occupies bits [i*SEC_W +: SEC_W].
- seconds_flat  out  NUM_CH*SEC_W  per-channel seconds, same packing as load_value.
- sec_pulse  out  NUM_CH  1-cycle strobe, high in the cycle seconds changes.
- expire_pulse  out  NUM_CH  1-cycle strobe on entry to DONE.
- expired  out  NUM_CH  level, high while channel is in DONE.

Behaviour:
- All logic is on posedge clk_game. Reset is sampled synchronously when reset==0.
- Reset values, all channels:
  - seconds = 0, tick = 0, state IDLE.
  - sec_pulse = 0, expire_pulse = 0, expired = 0.
- Per-channel priority: reset > clear > load > count.
- ch_clear: seconds=0, tick=0, state IDLE, expired=0, pulses=0.
- ch_load: seconds=min(load_value_i, MAX_SEC), tick=0, state IDLE, expired=0. No pulses in the load cycle.
- Per-channel states:
  - IDLE: if ch_enable → RUN, and the tick counts in this same cycle.
  - RUN: ch_enable low → IDLE with tick retained (pause/resume is lossless). ch_enable high → counting continues.
  - DONE: seconds frozen; ch_enable ignored. Exit only via clear, load or reset.
- Tick counting: tick increments 0..TICKS_PER_SEC-1 in every cycle where ch_enable=1 and state≠DONE.
- Boundary cycle (tick==TICKS_PER_SEC-1 while counting):
  - tick←0.
  - Up mode: seconds←seconds+1.
  - Down mode: seconds←seconds-1.
  - sec_pulse=1 in the following cycle, coincident with the new seconds value.
- Terminal condition:
  - Up mode: the new value == MAX_SEC.
  - Down mode: the new value == 0.
  - On terminal: state←DONE, expired←1, expire_pulse=1 for exactly one cycle. Registered together with sec_pulse.
- Degenerate start: enable asserted with seconds already terminal (down & 0, or up & MAX_SEC) → DONE and expire_pulse on the next edge. No tick counting, no sec_pulse.
- ch_down is sampled only at the boundary cycle. Changing it mid-second affects only the next step direction. Changing it does not re-evaluate DONE.
- Arithmetic never wraps: no increment above MAX_SEC, no decrement below 0.
- Channels are fully independent. Simultaneous events on different channels never interact.
- First second update occurs exactly TICKS_PER_SEC enabled cycles after enable rises.

Optional Feature:
- GAME_TIMER_BCD_EN defined:
  - Adds output bcd_flat, NUM_CH*8 bits: per channel {tens, ones} BCD of seconds.
  - Registered, updating in the same cycle as seconds_flat.
  - Reset value 0.
  - Requires MAX_SEC ≤ 99; elaboration error otherwise.
- Undefined: bcd_flat port and its logic are absent. All other behaviour is identical.

Test Plan:
- Reset: hold reset=0 for 3 cycles during counting → seconds_flat=0, expired=0, all pulses 0; counting restarts from tick 0 after release.
- Up-count saturation, ch0: up, enable held → seconds=1 after 60 cycles; sec_pulse every 60 cycles; after 99*60=5940 cycles seconds=99, expired=1, expire_pulse single cycle. Further 200 cycles → seconds remains 99, no sec_pulse.
- Down-count, ch1: load 3 (clamped path untested), down, enable → sequence 2,1,0 at cycles 60/120/180; expire_pulse with the 0 value. Then load 200 → seconds=99 (clamp), expired=0.
- Pause: enable ch0 for 30 cycles, drop enable for 100 cycles, re-enable → first increment after 30 further cycles (tick retained).
- Priority/simultaneity: ch_clear and ch_load same cycle on ch0 → seconds=0. Load and boundary tick same cycle → load value wins, no sec_pulse. ch1 unaffected throughout.
- Degenerate start: down mode, seconds=0, enable → expire_pulse on the next edge, no sec_pulse. With GAME_TIMER_BCD_EN, seconds=47 → bcd 8'h47.
